rvc_asap_5pl_cr_arb: RTL and testbench
======================================

# rvc_asap_5pl_cr_arb

Arbiter in front of `rvc_asap_5pl_cr_mem` that shares the single CR memory access port between the core's memory stage and a debug/host requester. Core accesses have priority and pass through with zero added latency. Debug accesses use a req/gnt handshake. A starvation counter guarantees forward progress for a waiting debug request by stalling the core for one cycle.

## Interface
Parameters:
- `STARVE_MAX`, default 8: number of consecutive blocked cycles a pending debug request tolerates before a forced grant; legal range 1..255.

Ports:
- `Clock`  in  1  single clock; all state on its rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `CoreCRWrEn`  in  1  core store to CR space (Q103H).
- `CoreCRRdEn`  in  1  core load from CR space (Q103H).
- `CoreAddr`  in  32  core CR offset (AluOut).
- `CoreWrData`  in  32  core store data (RegRdData2).
- `CoreStall`  out  1  freeze the core's Q103H stage this cycle.
- `DbgReq`  in  1  debug request; held with stable fields until granted.
- `DbgWe`  in  1  1 = write, 0 = read.
- `DbgAddr`  in  32  debug CR offset.
- `DbgWrData`  in  32  debug write data.
- `DbgGnt`  out  1  one-cycle pulse; the debug access issues to CR memory in this cycle.
- `DbgRdValid`  out  1  debug read data valid pulse.
- `DbgRdData`  out  32  debug read data, held until the next valid pulse.
- `CRMemWrEn`  out  1  to CR memory `CtrlCRMemWrEn`.
- `CRMemRdEn`  out  1  to CR memory `SelCRMemWb`.
- `CRMemAddr`  out  32  to CR memory `AluOut`.
- `CRMemWrData`  out  32  to CR memory `RegRdData2`.
- `CRMemRdDataQ104H`  in  32  registered read data from CR memory.

## Operation
- Core access: `CoreCRWrEn | CoreCRRdEn`. The core owns the port whenever it accesses, except in the FORCE state. Core `CoreCRWrEn`/`CoreCRRdEn`/`CoreAddr`/`CoreWrData` are muxed straight to the CR memory port.
- States:
  - IDLE: no pending debug request.
    - `DbgReq` high and no core access: `DbgGnt`=1, debug fields drive the CR port, stay in IDLE.
    - `DbgReq` high and core access: go to WAIT, WaitCnt←1.
  - WAIT: debug request pending.
    - No core access: grant this cycle, WaitCnt←0, go to IDLE.
    - Core access: WaitCnt←WaitCnt+1. If WaitCnt==STARVE_MAX-1, go to FORCE.
  - FORCE: `CoreStall`=1, debug access issued, `DbgGnt`=1, WaitCnt←0, go to IDLE unconditionally. The core holds its access and replays it next cycle.
- With STARVE_MAX=1, the first blocked cycle moves from IDLE directly to FORCE.
- Debug write: in the grant cycle, `CRMemWrEn`=1, `CRMemAddr`=`DbgAddr`, `CRMemWrData`=`DbgWrData`.
- Debug read: in the grant cycle, `CRMemRdEn`=1 and a RdOwner flag register is set. The next cycle, `DbgRdValid`=1 and `DbgRdData`←`CRMemRdDataQ104H`.
- Core reads get `CRMemRdDataQ104H` directly; the arbiter never alters it.
- Counter width is $clog2(STARVE_MAX+1). WaitCnt never wraps; it saturates by leaving WAIT.
- `DbgReq` dropped while in WAIT without a grant is a protocol violation. The required behaviour is defined anyway: return to IDLE, WaitCnt←0, no access issued.

## Timing
- Reset (`Rst`=0, asynchronous):
  - State=IDLE, WaitCnt=0, RdOwner=0.
  - `DbgGnt`=0, `DbgRdValid`=0, `DbgRdData`=0, `CoreStall`=0.
  - CR port outputs are all 0 while `Rst` is low.
- CR port mux and `DbgGnt`/`CoreStall` are combinational from state and inputs; zero added latency for the core.
- Debug grant latency:
  - 0 cycles when the core is idle.
  - At most STARVE_MAX cycles after `DbgReq` rises under continuous core traffic.
- Debug read latency: `DbgRdValid` one cycle after `DbgGnt`.
- Back-to-back debug requests: a new request may be presented the cycle after `DbgGnt`. Arbitration restarts in IDLE.
- Reset mid-operation: a pending request and any in-flight read are dropped; no `DbgRdValid` follows reset.

## Configuration
- `CR_ARB_DBG_WR_EN` defined: debug writes are issued as described above.
- Not defined: debug is read-only.
  - Write requests are still granted so the handshake completes, but `CRMemWrEn` stays 0 in that cycle and no state changes.
  - The debug write path logic is not compiled.

## Test plan
- Idle core, DbgReq read of CR_Switch with Switch=10'h2A5: `DbgGnt` in cycle 0; `DbgRdValid`=1 with `DbgRdData`=32'h2A5 in cycle 1; `CoreStall` never asserted.
- Continuous core loads, STARVE_MAX=8, DbgReq write 7'h3F to CR_LED: WAIT for 7 cycles, FORCE on the 8th with `CoreStall`=1 and `DbgGnt`=1; LED=7'h3F after the CR memory latency.
- Core traffic with a gap in the 3rd blocked cycle: grant in the gap cycle, no `CoreStall`, WaitCnt returns to 0.
- `Rst` pulled low in the cycle after a debug read grant: no `DbgRdValid`; all outputs 0; the next request behaves as from reset.
- `CR_ARB_DBG_WR_EN` undefined, debug write 7'h55 to CR_SEG7_0: `DbgGnt` pulses, `CRMemWrEn` stays 0, SEG7_0 is unchanged.
- STARVE_MAX=1 under core traffic: FORCE entered on the first blocked cycle, with `CoreStall` lasting exactly 1 cycle.

Source files
------------

// File: rtl/rvc_asap_5pl_cr_arb.sv
// rvc_asap_5pl_cr_arb
// Shares the single CR memory access port between the core memory stage and a
// debug/host requester. Core accesses pass straight through with no added
// latency. Debug accesses use a req/gnt handshake. A starvation counter forces
// a grant, stalling the core for one cycle, when a debug request has waited
// too long.
//
// Build option: define CR_ARB_DBG_WR_EN to let debug writes reach CR memory.
// Without it the debug port is read-only. Write requests are still granted so
// the handshake completes, but no write enable is issued.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no debug request pending; a request with an idle core is granted
// S_WAIT  | debug request blocked by core traffic; counting blocked cycles
// S_FORCE | starvation limit hit; core stalled, debug access issued
module rvc_asap_5pl_cr_arb #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        CoreCRWrEn,
  input  logic        CoreCRRdEn,
  input  logic [31:0] CoreAddr,
  input  logic [31:0] CoreWrData,
  output logic        CoreStall,
  input  logic        DbgReq,
  input  logic        DbgWe,
  input  logic [31:0] DbgAddr,
  input  logic [31:0] DbgWrData,
  output logic        DbgGnt,
  output logic        DbgRdValid,
  output logic [31:0] DbgRdData,
  output logic        CRMemWrEn,
  output logic        CRMemRdEn,
  output logic [31:0] CRMemAddr,
  output logic [31:0] CRMemWrData,
  input  logic [31:0] CRMemRdDataQ104H
);

  localparam int unsigned   CW       = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_cnt_nxt;
  logic          r_rd_owner;
  logic [31:0]   r_rd_hold;

  logic          w_core_acc;
  logic          w_dbg_issue;
  logic          w_core_stall;
  logic          w_dbg_rd;
  logic          w_dbg_wr;

  logic          w_mem_we;
  logic          w_mem_re;
  logic [31:0]   w_mem_addr;
  logic [31:0]   w_mem_wd;

  assign w_core_acc = CoreCRWrEn | CoreCRRdEn;

  // State, wait counter and read-ownership registers
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= CNT_ZERO;
      r_rd_owner <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_rd_owner <= w_dbg_rd;
    end
  end

  // Next-state, counter update and grant/stall decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_dbg_issue    = 1'b0;
    w_core_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (DbgReq) begin
          if (!w_core_acc) begin
            w_dbg_issue = 1'b1;
          end else if (STARVE_MAX == 1) begin
            // A single tolerated blocked cycle means the very first one forces.
            w_state_nxt    = S_FORCE;
            w_wait_cnt_nxt = CNT_ONE;
          end else begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = CNT_ONE;
          end
        end
      end
      S_WAIT: begin
        if (!DbgReq) begin
          // Requester withdrew without a grant: abandon it, issue nothing.
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = CNT_ZERO;
        end else if (!w_core_acc) begin
          w_dbg_issue    = 1'b1;
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = CNT_ZERO;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
          if (r_wait_cnt >= CNT_LAST) begin
            w_state_nxt = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        // The core holds its access during the stall and replays it next cycle.
        w_core_stall   = 1'b1;
        w_dbg_issue    = 1'b1;
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = CNT_ZERO;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  assign w_dbg_rd = w_dbg_issue & ~DbgWe;

`ifdef CR_ARB_DBG_WR_EN
  assign w_dbg_wr = w_dbg_issue & DbgWe;
`else
  assign w_dbg_wr = 1'b0;
`endif

  // CR port mux: debug fields in a grant cycle, otherwise the core passes through
  always_comb begin
    w_mem_we   = CoreCRWrEn;
    w_mem_re   = CoreCRRdEn;
    w_mem_addr = CoreAddr;
    w_mem_wd   = CoreWrData;
    if (w_dbg_issue) begin
      w_mem_we   = w_dbg_wr;
      w_mem_re   = w_dbg_rd;
      w_mem_addr = DbgAddr;
      w_mem_wd   = DbgWrData;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign CRMemWrEn   = Rst & w_mem_we;
  assign CRMemRdEn   = Rst & w_mem_re;
  assign CRMemAddr   = w_mem_addr & {32{Rst}};
  assign CRMemWrData = w_mem_wd & {32{Rst}};
  assign DbgGnt      = Rst & w_dbg_issue;
  assign CoreStall   = Rst & w_core_stall;

  // Capture returned debug read data so it stays visible after the valid pulse
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_rd_hold <= 32'h0;
    end else if (r_rd_owner) begin
      r_rd_hold <= CRMemRdDataQ104H;
    end
  end

  assign DbgRdValid = r_rd_owner;
  assign DbgRdData  = r_rd_owner ? CRMemRdDataQ104H : r_rd_hold;

endmodule

// File: tb/tb_rvc_asap_5pl_cr_arb.sv
// Self-checking bench for rvc_asap_5pl_cr_arb. Two instances share stimulus:
// STARVE_MAX=8 (drives a behavioural CR memory) and STARVE_MAX=1.
module tb_rvc_asap_5pl_cr_arb;

`ifdef CR_ARB_DBG_WR_EN
  localparam logic DBG_WR = 1'b1;
`else
  localparam logic DBG_WR = 1'b0;
`endif

  localparam logic [31:0] A_CORE = 32'h10;
  localparam logic [31:0] A_SW   = 32'h20;
  localparam logic [31:0] A_LED  = 32'h24;
  localparam logic [31:0] A_SEG0 = 32'h28;
  localparam logic [31:0] A_SCR  = 32'h30;

  logic        Clock = 1'b0;
  logic        Rst   = 1'b0;
  logic        CoreCRWrEn, CoreCRRdEn, DbgReq, DbgWe;
  logic [31:0] CoreAddr, CoreWrData, DbgAddr, DbgWrData;
  logic [31:0] rd_q;

  logic        CoreStall, DbgGnt, DbgRdValid, CRMemWrEn, CRMemRdEn;
  logic [31:0] DbgRdData, CRMemAddr, CRMemWrData;
  logic        CoreStall_1, DbgGnt_1, DbgRdValid_1, CRMemWrEn_1, CRMemRdEn_1;
  logic [31:0] DbgRdData_1, CRMemAddr_1, CRMemWrData_1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:63];
  logic        mem_loaded = 1'b0;

  rvc_asap_5pl_cr_arb #(.STARVE_MAX(8)) dut (
    .Clock(Clock), .Rst(Rst),
    .CoreCRWrEn(CoreCRWrEn), .CoreCRRdEn(CoreCRRdEn),
    .CoreAddr(CoreAddr), .CoreWrData(CoreWrData), .CoreStall(CoreStall),
    .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWrData(DbgWrData),
    .DbgGnt(DbgGnt), .DbgRdValid(DbgRdValid), .DbgRdData(DbgRdData),
    .CRMemWrEn(CRMemWrEn), .CRMemRdEn(CRMemRdEn), .CRMemAddr(CRMemAddr),
    .CRMemWrData(CRMemWrData), .CRMemRdDataQ104H(rd_q)
  );

  rvc_asap_5pl_cr_arb #(.STARVE_MAX(1)) dut1 (
    .Clock(Clock), .Rst(Rst),
    .CoreCRWrEn(CoreCRWrEn), .CoreCRRdEn(CoreCRRdEn),
    .CoreAddr(CoreAddr), .CoreWrData(CoreWrData), .CoreStall(CoreStall_1),
    .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWrData(DbgWrData),
    .DbgGnt(DbgGnt_1), .DbgRdValid(DbgRdValid_1), .DbgRdData(DbgRdData_1),
    .CRMemWrEn(CRMemWrEn_1), .CRMemRdEn(CRMemRdEn_1), .CRMemAddr(CRMemAddr_1),
    .CRMemWrData(CRMemWrData_1), .CRMemRdDataQ104H(rd_q)
  );

  always #5 Clock = ~Clock;

  // Behavioural CR memory behind the STARVE_MAX=8 instance, registered read.
  always @(posedge Clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[A_SW[7:2]]   = 32'h2A5;
      mem[A_SEG0[7:2]] = 32'h11;
      mem[A_SCR[7:2]]  = 32'h5A5A;
      mem_loaded = 1'b1;
    end
    if (CRMemWrEn) mem[CRMemAddr[7:2]] = CRMemWrData;
    if (CRMemRdEn) rd_q <= mem[CRMemAddr[7:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every debug read valid pulse pops one expected value.
  always @(negedge Clock) begin
    if (DbgRdValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got valid with data %h, required no valid (t=%0t)", DbgRdData, $time);
      end else begin
        chk("rd_data", DbgRdData, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic cw, input logic cr, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dd);
    CoreCRWrEn = cw; CoreCRRdEn = cr; CoreAddr = ca; CoreWrData = cd;
    DbgReq = dr; DbgWe = dwe; DbgAddr = da; DbgWrData = dd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
  endtask

  // Continuous core loads with a debug request: force grant in cycle 8.
  task automatic starve8(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_mem);
    for (int i = 0; i <= 8; i++) begin
      drive(0, 1, A_CORE, 0, 1, we, addr, wd);
      #1;
      chk($sformatf("starve_gnt_c%0d", i), DbgGnt, i == 8);
      chk($sformatf("starve_stall_c%0d", i), CoreStall, i == 8);
      if (i == 8) begin
        chk("starve_addr", CRMemAddr, addr);
        chk("starve_we", CRMemWrEn, we & DBG_WR);
        chk("starve_wd", CRMemWrData, wd);
      end else if (i == 3) begin
        chk("starve_core_addr", CRMemAddr, A_CORE);
      end
      tick();
    end
    idle();
    #1;
    chk("starve_stall_after", CoreStall, 0);
    tick();
    chk("starve_mem", mem[addr[7:2]], exp_mem);
  endtask

  typedef struct {
    logic cw, cr; logic [31:0] ca, cd;
    logic dr, dwe; logic [31:0] da, dd;
    logic e_stall, e_gnt, e_we, e_re; logic [31:0] e_addr, e_wd;
    logic push; logic [31:0] rd_exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Reset with live inputs: every output must sit at 0.
    drive(0, 1, A_CORE, 32'h1234, 1, 0, A_SW, 0);
    #2;
    chk("rst_we", CRMemWrEn, 0);
    chk("rst_re", CRMemRdEn, 0);
    chk("rst_addr", CRMemAddr, 0);
    chk("rst_wd", CRMemWrData, 0);
    chk("rst_gnt", DbgGnt, 0);
    chk("rst_stall", CoreStall, 0);
    chk("rst_valid", DbgRdValid, 0);
    chk("rst_rdata", DbgRdData, 0);
    idle();
    tick();
    Rst = 1'b1;

    //             cw cr ca      cd        dr dwe da     dd     stl gnt we      re addr    wd        push rd_exp
    tbl[0] = '{0, 0, 0,      0,        0, 0, 0,     0,     0, 0, 0,      0, 0,      0,        0, 0};
    tbl[1] = '{1, 0, A_CORE, 32'hAAAA, 0, 0, 0,     0,     0, 0, 1,      0, A_CORE, 32'hAAAA, 0, 0};
    tbl[2] = '{0, 1, A_CORE, 0,        0, 0, 0,     0,     0, 0, 0,      1, A_CORE, 0,        0, 0};
    tbl[3] = '{0, 0, 0,      0,        1, 0, A_SW,  0,     0, 1, 0,      1, A_SW,   0,        1, 32'h2A5};
    tbl[4] = '{0, 1, A_CORE, 0,        1, 1, A_SCR, 32'h3F,0, 0, 0,      1, A_CORE, 0,        0, 0};
    tbl[5] = '{0, 1, A_CORE, 0,        1, 1, A_SCR, 32'h3F,0, 0, 0,      1, A_CORE, 0,        0, 0};
    tbl[6] = '{0, 0, 0,      0,        1, 1, A_SCR, 32'h3F,0, 1, DBG_WR, 0, A_SCR,  32'h3F,   0, 0};
    tbl[7] = '{0, 0, 0,      0,        1, 0, A_SCR, 0,     0, 1, 0,      1, A_SCR,  0,        1,
               DBG_WR ? 32'h3F : 32'h5A5A};
    tbl[8] = '{0, 0, 0,      0,        0, 0, 0,     0,     0, 0, 0,      0, 0,      0,        0, 0};

    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].cw, tbl[v].cr, tbl[v].ca, tbl[v].cd, tbl[v].dr, tbl[v].dwe, tbl[v].da, tbl[v].dd);
      #1;
      chk($sformatf("v%0d_stall", v), CoreStall, tbl[v].e_stall);
      chk($sformatf("v%0d_gnt", v), DbgGnt, tbl[v].e_gnt);
      chk($sformatf("v%0d_we", v), CRMemWrEn, tbl[v].e_we);
      chk($sformatf("v%0d_re", v), CRMemRdEn, tbl[v].e_re);
      chk($sformatf("v%0d_addr", v), CRMemAddr, tbl[v].e_addr);
      chk($sformatf("v%0d_wd", v), CRMemWrData, tbl[v].e_wd);
      if (tbl[v].push) exp_q.push_back(tbl[v].rd_exp);
      tick();
    end
    chk("rdata_held", DbgRdData, DBG_WR ? 32'h3F : 32'h5A5A);
    chk("rvalid_low_after", DbgRdValid, 0);

    // Gap in the 3rd blocked cycle: grant without stall, then a full
    // starvation run proves the counter restarted from 0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, i != 2, A_CORE, 0, 1, 0, A_SW, 0);
      #1;
      chk($sformatf("gap_gnt_c%0d", i), DbgGnt, i == 2);
      chk($sformatf("gap_stall_c%0d", i), CoreStall, 0);
      if (i == 2) begin
        chk("gap_re", CRMemRdEn, 1);
        chk("gap_addr", CRMemAddr, A_SW);
        exp_q.push_back(32'h2A5);
      end
      tick();
    end
    starve8(1, A_LED, 32'h3F, DBG_WR ? 32'h3F : 32'h0);

    // Debug write to SEG7_0 with an idle core.
    drive(0, 0, 0, 0, 1, 1, A_SEG0, 32'h55);
    #1;
    chk("seg_gnt", DbgGnt, 1);
    chk("seg_we", CRMemWrEn, DBG_WR);
    chk("seg_re", CRMemRdEn, 0);
    tick();
    idle();
    tick();
    chk("seg_mem", mem[A_SEG0[7:2]], DBG_WR ? 32'h55 : 32'h11);

    // STARVE_MAX=1: force on the first blocked cycle, one-cycle stall.
    // The STARVE_MAX=8 instance sees the request withdrawn while waiting.
    do_reset();
    drive(0, 1, A_CORE, 0, 1, 0, A_SW, 0);
    #1;
    chk("s1_c0_gnt", DbgGnt_1, 0);
    chk("s1_c0_stall", CoreStall_1, 0);
    tick();
    #1;
    chk("s1_c1_gnt", DbgGnt_1, 1);
    chk("s1_c1_stall", CoreStall_1, 1);
    chk("s1_c1_re", CRMemRdEn_1, 1);
    chk("s1_c1_addr", CRMemAddr_1, A_SW);
    chk("s8_c1_gnt", DbgGnt, 0);
    tick();
    drive(0, 1, A_CORE, 0, 0, 0, 0, 0);
    #1;
    chk("s1_c2_stall", CoreStall_1, 0);
    chk("s1_c2_gnt", DbgGnt_1, 0);
    chk("s1_c2_valid", DbgRdValid_1, 1);
    chk("s8_drop_gnt", DbgGnt, 0);
    chk("s8_drop_addr", CRMemAddr, A_CORE);
    tick();
    drive(0, 0, 0, 0, 1, 0, A_SW, 0);
    #1;
    chk("s8_after_drop_gnt", DbgGnt, 1);
    exp_q.push_back(32'h2A5);
    tick();
    idle();
    tick();

    // Reset in the cycle after a debug read grant: the read is dropped.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, A_SW, 0);
    #1;
    chk("mr_gnt", DbgGnt, 1);
    tick();
    Rst = 1'b0;
    drive(0, 1, A_CORE, 0, 1, 0, A_SW, 0);
    #1;
    chk("mr_valid", DbgRdValid, 0);
    chk("mr_rdata", DbgRdData, 0);
    chk("mr_gnt_low", DbgGnt, 0);
    chk("mr_re", CRMemRdEn, 0);
    chk("mr_addr", CRMemAddr, 0);
    tick();
    idle();
    Rst = 1'b1;
    tick();
    chk("mr_no_valid", DbgRdValid, 0);
    drive(0, 0, 0, 0, 1, 0, A_SW, 0);
    #1;
    chk("mr_next_gnt", DbgGnt, 1);
    exp_q.push_back(32'h2A5);
    tick();
    idle();
    tick();
    tick();

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
